// File: rtl/fp_round_pack.sv
// Rounding/packing back end of the 12-bit int to 8-bit float converter.
// S1 extracts E0/F0/R from the magnitude; S2 (the output registers) rounds half-up and saturates.
module fp_round_pack #(
  parameter int MAG_W = 11,
  parameter int IDX_W = 4,
  parameter int EXP_W = 3,
  parameter int SIG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [MAG_W-1:0] in_mag,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_sig,
  output logic             out_sat
);

  // Handshake: a transfer happens on any edge where valid && ready at that interface.
  // in_ready depends only on registered state and out_ready, never on in_* data.

  localparam logic [IDX_W-1:0] IDX_LO = IDX_W'(SIG_W);
  localparam logic [IDX_W-1:0] E_OFS  = IDX_W'(SIG_W - 1);
  localparam logic [IDX_W:0]   E_MAX  = (IDX_W + 1)'((1 << EXP_W) - 1);
  localparam logic [SIG_W-1:0] F_CARRY = SIG_W'(1 << (SIG_W - 1));

  logic             s2_adv;
  logic             s1_valid;
  logic             s1_sign;
  logic [IDX_W-1:0] s1_e0;
  logic [SIG_W-1:0] s1_f0;
  logic             s1_r;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // Stage 1 field extraction
  logic [MAG_W-1:0] f_sh;
  logic [MAG_W-1:0] r_sh;
  logic [IDX_W-1:0] e0_c;
  logic [SIG_W-1:0] f0_c;
  logic             r_c;

  always_comb begin
    e0_c = '0;
    f_sh = in_mag;
    r_sh = '0;
    f0_c = in_mag[SIG_W-1:0];
    r_c  = 1'b0;
    if (in_idx >= IDX_LO) begin
      e0_c = in_idx - E_OFS;
      f_sh = in_mag >> e0_c;
      r_sh = in_mag >> (in_idx - IDX_LO);
      f0_c = f_sh[SIG_W-1:0];
      r_c  = r_sh[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_e0    <= '0;
      s1_f0    <= '0;
      s1_r     <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_e0   <= e0_c;
        s1_f0   <= f0_c;
        s1_r    <= r_c;
      end
    end
  end

  // Stage 2 rounding: a carry out of F renormalises to F=8 with E+1
  logic [SIG_W:0]   f1;
  logic [IDX_W:0]   e1;
  logic [EXP_W-1:0] exp_c;
  logic [SIG_W-1:0] sig_c;
  logic             sat_c;

  always_comb begin
    f1    = {1'b0, s1_f0} + (SIG_W + 1)'(s1_r);
    e1    = {1'b0, s1_e0} + (IDX_W + 1)'(f1[SIG_W]);
    sig_c = f1[SIG_W] ? F_CARRY : f1[SIG_W-1:0];
    exp_c = e1[EXP_W-1:0];
    sat_c = 1'b0;
    if (e1 > E_MAX) begin
      exp_c = '1;
      sig_c = '1;
      sat_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_sig   <= '0;
      out_sat   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign <= s1_sign;
        out_exp  <= exp_c;
        out_sig  <= sig_c;
        out_sat  <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pack.sv
// Directed + randomised bench for fp_round_pack with a queue scoreboard.
// All time advances go through tick(), which samples at the falling edge.
module tb_fp_round_pack;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [10:0] in_mag;
  logic [3:0]  in_idx;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [2:0]  out_exp;
  logic [3:0]  out_sig;
  logic        out_sat;

  int tests = 0;
  int fails = 0;
  int out_cnt = 0;
  int stall_cycles = 0;
  int cnt0;
  bit rand_bp = 0;
  logic neg_in_ready;
  logic [8:0] exp_q[$];

  fp_round_pack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_mag    (in_mag),
    .in_idx    (in_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_sig   (out_sig),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: round-half-up by adding half an LSB before shifting. Packs {S,E,F,sat}.
  function automatic logic [8:0] model(input logic s, input int mag, input int idx);
    int sh, q, e, f;
    logic sat;
    sat = 1'b0;
    if (idx < 4) begin
      e = 0;
      f = mag & 15;
    end else begin
      sh = idx - 3;
      q  = (mag + (1 << (sh - 1))) >> sh;
      if (q >= 16) begin
        f = 8;
        e = sh + 1;
      end else begin
        f = q;
        e = sh;
      end
    end
    if (e > 7) begin
      e = 7;
      f = 15;
      sat = 1'b1;
    end
    return {s, e[2:0], f[3:0], sat};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: scoreboard at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    logic [8:0] e;
    @(negedge clk);
    neg_in_ready = in_ready;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("q_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_result", {23'd0, out_sign, out_exp, out_sig, out_sat}, {23'd0, e});
        end
        out_cnt++;
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_sign, int'(in_mag), int'(in_idx)));
    end
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic s, input int mag, input int idx);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_sign  = s;
    in_mag   = 11'(mag);
    in_idx   = 4'(idx);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (neg_in_ready) begin
        done = 1'b1;
        break;
      end
      stall_cycles++;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [8:0] exp);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        check(tag, {23'd0, out_sign, out_exp, out_sig, out_sat}, {23'd0, exp});
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int m, ix;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sign = 1'b0;
    in_mag = '0;
    in_idx = '0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_outputs", {23'd0, out_sign, out_exp, out_sig, out_sat}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // 1: zero, latency check
    send(1'b0, 0, 0);
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_edge2_valid", 32'(out_valid), 32'd1);
    check("zero_result", {23'd0, out_sign, out_exp, out_sig, out_sat}, 32'h000);

    // 2-4: rounding cases with spec-given answers
    send(1'b1, 422, 8);
    wait_out("t2_422", {1'b1, 3'd5, 4'd13, 1'b0});
    send(1'b0, 252, 7);
    wait_out("t3_carry", {1'b0, 3'd5, 4'd8, 1'b0});
    send(1'b0, 2047, 10);
    wait_out("t4_sat", {1'b0, 3'd7, 4'd15, 1'b1});
    tick();
    tick();

    // 5: small exact values back to back
    send(1'b0, 5, 2);
    send(1'b0, 15, 3);
    check("b2b_first_valid", 32'(out_valid), 32'd1);
    check("b2b_first_sig", 32'(out_sig), 32'd5);
    tick();
    check("b2b_second_valid", 32'(out_valid), 32'd1);
    check("b2b_second_sig", {24'd0, out_exp, out_sig, out_sat}, {24'd0, 3'd0, 4'd15, 1'b0});

    // Full-throughput stream: simultaneous accept and drain must never stall
    stall_cycles = 0;
    send(1'b1, 31, 4);
    send(1'b0, 1023, 9);
    send(1'b1, 1, 0);
    send(1'b0, 1536, 10);
    send(1'b1, 100, 6);
    send(1'b0, 47, 5);
    send(1'b1, 8, 3);
    send(1'b0, 1000, 9);
    check("stream_no_stall", 32'(stall_cycles), 32'd0);
    for (int i = 0; i < 3; i++) tick();

    // 6: backpressure
    out_ready = 1'b0;
    cnt0 = out_cnt;
    send(1'b1, 422, 8);
    send(1'b0, 252, 7);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_sign = 1'b0;
    in_mag = 11'd2047;
    in_idx = 4'd10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_ready", 32'(in_ready), 32'd0);
      check("bp_hold_out", {22'd0, out_valid, out_sign, out_exp, out_sig, out_sat},
            {22'd0, 1'b1, 1'b1, 3'd5, 4'd13, 1'b0});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (neg_in_ready) break;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("bp_drained_cnt", 32'(out_cnt - cnt0), 32'd3);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset flush with a full pipe
    out_ready = 1'b0;
    send(1'b1, 700, 9);
    send(1'b0, 300, 8);
    check("flush_pre_valid", 32'(out_valid), 32'd1);
    cnt0 = out_cnt;
    rst_n = 1'b0;
    #1;
    check("flush_async_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_outputs", {23'd0, out_sign, out_exp, out_sig, out_sat}, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("flush_no_stale", 32'(out_cnt - cnt0), 32'd0);

    // Randomised traffic under random backpressure
    rand_bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      ix = $urandom_range(0, 10);
      if (ix == 0) m = $urandom_range(0, 1);
      else m = (1 << ix) | $urandom_range(0, (1 << ix) - 1);
      send(1'($urandom_range(0, 1)), m, ix);
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
